// File: rtl/gpio_ext_pkg.sv
// Shared register offsets and types for the gpio_ext peripheral.
package gpio_ext_pkg;

  localparam logic [11:0] OFF_ODR  = 12'h000;
  localparam logic [11:0] OFF_IDR  = 12'h004;
  localparam logic [11:0] OFF_RIER = 12'h008;
  localparam logic [11:0] OFF_RISR = 12'h00c;
  localparam logic [11:0] OFF_FIER = 12'h010;
  localparam logic [11:0] OFF_FISR = 12'h014;
  localparam logic [11:0] OFF_DIR  = 12'h018;
  localparam logic [11:0] OFF_BSR  = 12'h01c;
  localparam logic [11:0] OFF_BCR  = 12'h020;
  localparam logic [11:0] OFF_FILT = 12'h024;

  typedef struct packed {
    logic [31:0] odr;
    logic [31:0] rier;
    logic [31:0] risr;
    logic [31:0] fier;
    logic [31:0] fisr;
    logic [31:0] dir;
    logic [31:0] filt;
  } gpio_ext_regs_t;

  // Per-pin filter result: debounced level plus single-cycle edge pulses.
  typedef struct packed {
    logic filt;
    logic rise;
    logic fall;
  } pin_state_t;

endpackage

// File: rtl/gpio_ext_filter.sv
// One pin: synchronizer chain, debounce counter, filtered level and edge pulses.
module gpio_ext_filter
  import gpio_ext_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin,
  input  logic [FILT_W-1:0] thresh,
  output pin_state_t        state
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   f_q;
  logic                   f_prev_q;
  logic [FILT_W-1:0]      cnt_q;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      f_q      <= 1'b0;
      f_prev_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin};
      f_prev_q <= f_q;
      if (s == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == thresh) begin
        f_q   <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign state.filt = f_q;
  assign state.rise = f_q & ~f_prev_q;
  assign state.fall = ~f_q & f_prev_q;

endmodule

// File: rtl/gpio_ext.sv
// GPIO peripheral: bus decode, register file, per-pin filters and interrupt aggregation.
module gpio_ext
  import gpio_ext_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [11:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_rvalid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [31:0] PIN_MASK  = (WIDTH  >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH)  - 32'd1);
  localparam logic [31:0] FILT_MASK = (FILT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << FILT_W) - 32'd1);

  gpio_ext_regs_t   regs_q;
  pin_state_t       pin_st [WIDTH];
  logic [WIDTH-1:0] filt_v, rise_v, fall_v;
  logic [31:0]      idr, rise_w, fall_w;
  logic [31:0]      rd_mux, risr_clr, fisr_clr;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_ext_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (gpio_in[i]),
      .thresh(regs_q.filt[FILT_W-1:0]),
      .state (pin_st[i])
    );
    assign filt_v[i] = pin_st[i].filt;
    assign rise_v[i] = pin_st[i].rise;
    assign fall_v[i] = pin_st[i].fall;
  end

  assign idr    = 32'(filt_v);
  assign rise_w = 32'(rise_v);
  assign fall_w = 32'(fall_v);
  assign wr     = bus_req & bus_we;

  // W1C masks; an edge arriving in the same cycle is OR-ed in afterwards so the set wins.
  assign risr_clr = (wr && bus_addr == OFF_RISR) ? bus_wdata : 32'd0;
  assign fisr_clr = (wr && bus_addr == OFF_FISR) ? bus_wdata : 32'd0;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = 32'd0;
    case (bus_addr)
      OFF_ODR:  rd_mux = regs_q.odr;
      OFF_IDR:  rd_mux = idr;
      OFF_RIER: rd_mux = regs_q.rier;
      OFF_RISR: rd_mux = regs_q.risr;
      OFF_FIER: rd_mux = regs_q.fier;
      OFF_FISR: rd_mux = regs_q.fisr;
      OFF_DIR:  rd_mux = regs_q.dir;
      OFF_FILT: rd_mux = regs_q.filt;
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '0;
      bus_rvalid <= 1'b0;
      bus_rdata  <= 32'd0;
    end else begin
      bus_rvalid  <= bus_req;
      bus_rdata   <= (bus_req && !bus_we) ? rd_mux : 32'd0;
      regs_q.risr <= ((regs_q.risr & ~risr_clr) | (rise_w & regs_q.rier)) & PIN_MASK;
      regs_q.fisr <= ((regs_q.fisr & ~fisr_clr) | (fall_w & regs_q.fier)) & PIN_MASK;
      if (wr) begin
        case (bus_addr)
          OFF_ODR:  regs_q.odr  <= bus_wdata & PIN_MASK;
          OFF_BSR:  regs_q.odr  <= (regs_q.odr | bus_wdata) & PIN_MASK;
          OFF_BCR:  regs_q.odr  <= regs_q.odr & ~bus_wdata;
          OFF_RIER: regs_q.rier <= bus_wdata & PIN_MASK;
          OFF_FIER: regs_q.fier <= bus_wdata & PIN_MASK;
          OFF_DIR:  regs_q.dir  <= bus_wdata & PIN_MASK;
          OFF_FILT: regs_q.filt <= bus_wdata & FILT_MASK;
          default:  ;
        endcase
      end
    end
  end

  assign gpio_out = regs_q.odr[WIDTH-1:0];
  assign gpio_oe  = regs_q.dir[WIDTH-1:0];
  assign irq      = |(regs_q.risr | regs_q.fisr);

endmodule

// File: tb/tb_gpio_ext.sv
// Directed self-checking bench for gpio_ext: default build plus a WIDTH=5 build on a shared bus.
module tb_gpio_ext;
  import gpio_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req, bus_we;
  logic [11:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata, rdata5;
  logic        bus_rvalid, rvalid5;
  logic [31:0] gpio_in, gpio_out, gpio_oe;
  logic [4:0]  gpio_in5, gpio_out5, gpio_oe5;
  logic        irq, irq5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_ext u_dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_ext #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(rdata5), .bus_rvalid(rvalid5),
    .gpio_in(gpio_in5), .gpio_out(gpio_out5), .gpio_oe(gpio_oe5), .irq(irq5)
  );

  // Bus tasks start at a negedge and return at the next negedge (one request per cycle).
  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] d, output logic [31:0] d5,
                        output logic v);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_req = 1'b0;
    d = bus_rdata; d5 = rdata5; v = bus_rvalid;
  endtask

  task automatic test_reset();
    logic [31:0] d, d5;
    logic        v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (irq !== 1'b0 || gpio_oe !== 32'd0 || gpio_out !== 32'd0 || bus_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: irq=%b oe=%h out=%h rvalid=%b, required all 0",
               irq, gpio_oe, gpio_out, bus_rvalid);
    end
    for (int a = 0; a <= 12'h028; a += 4) begin
      bus_rd(12'(a), d, d5, v);
      n_tests++;
      if (d !== 32'd0 || v !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_read[%h]: data=%h rvalid=%b, required 0 / 1", a, d, v);
      end
    end
    // Write issued in the reset cycle must be dropped, along with its rvalid.
    rst = 1'b1;
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = OFF_ODR; bus_wdata = 32'h0000_00AA;
    @(negedge clk);
    rst = 1'b0; bus_req = 1'b0; bus_we = 1'b0;
    n_tests++;
    if (bus_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid: rvalid=%b, required 0", bus_rvalid);
    end
    bus_rd(OFF_ODR, d, d5, v);
    n_tests++;
    if (d !== 32'd0 || gpio_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_write_ignored: odr=%h out=%h, required 0", d, gpio_out);
    end
  endtask

  task automatic test_atomic_odr();
    logic [31:0] d, d5;
    logic        v;
    bus_wr(OFF_ODR, 32'h0000_00F0);
    bus_wr(OFF_BSR, 32'h0000_0003);
    bus_wr(OFF_BCR, 32'h0000_0010);
    bus_rd(OFF_ODR, d, d5, v);
    n_tests++;
    if (d !== 32'h0000_00E3 || gpio_out !== 32'h0000_00E3) begin
      n_fail++;
      $display("FAIL atomic_odr: odr=%h out=%h, required 000000e3", d, gpio_out);
    end
    bus_rd(OFF_BSR, d, d5, v);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL bsr_reads_zero: got %h, required 0", d);
    end
    bus_wr(OFF_DIR, 32'h0000_00FF);
    n_tests++;
    if (gpio_oe !== 32'h0000_00FF || gpio_out !== 32'h0000_00E3) begin
      n_fail++;
      $display("FAIL dir_oe: oe=%h out=%h, required 000000ff / 000000e3", gpio_oe, gpio_out);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d, d5;
    logic        v;
    bus_wr(OFF_RIER, 32'h1);
    gpio_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_early: irq=%b after 3 edges, required 0", irq);
    end
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_latency: irq=%b after 4 edges, required 1", irq);
    end
    bus_rd(OFF_RISR, d, d5, v);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL risr_set: got %h, required 00000001", d);
    end
    bus_wr(OFF_RISR, 32'h1);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL risr_w1c: irq=%b, required 0", irq);
    end
    gpio_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    bus_rd(OFF_FISR, d, d5, v);
    n_tests++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_disabled: fisr=%h irq=%b, required 0 / 0", d, irq);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d, d5;
    logic        v;
    bus_wr(OFF_FILT, 32'd5);
    bus_wr(OFF_RIER, 32'h8);
    bus_wr(OFF_FIER, 32'h8);
    gpio_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (12) @(negedge clk);
    bus_rd(OFF_IDR, d, d5, v);
    n_tests++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_reject: idr=%h irq=%b, required 0 / 0", d, irq);
    end
    gpio_in[3] = 1'b1;
    repeat (6) @(negedge clk);
    gpio_in[3] = 1'b0;
    @(negedge clk);
    bus_rd(OFF_IDR, d, d5, v);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL debounce_early: idr=%h before edge 8, required 0", d);
    end
    bus_rd(OFF_IDR, d, d5, v);
    n_tests++;
    if (d !== 32'h8 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL debounce_pass: idr=%h irq=%b, required 00000008 / 1", d, irq);
    end
    repeat (7) @(negedge clk);
    bus_rd(OFF_FISR, d, d5, v);
    n_tests++;
    if (d !== 32'h8) begin
      n_fail++;
      $display("FAIL debounce_fall: fisr=%h, required 00000008", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d, d5;
    logic        v;
    bus_wr(OFF_FILT, 32'd0);
    bus_wr(OFF_RISR, 32'hFFFF_FFFF);
    bus_wr(OFF_FISR, 32'hFFFF_FFFF);
    bus_wr(OFF_FIER, 32'd0);
    bus_wr(OFF_RIER, 32'h4);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL status_clear_all: irq=%b, required 0", irq);
    end
    gpio_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[2] = 1'b1;
    repeat (3) @(negedge clk);
    bus_wr(OFF_RISR, 32'h4);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_irq: irq=%b, required 1", irq);
    end
    bus_rd(OFF_RISR, d, d5, v);
    n_tests++;
    if (d !== 32'h4) begin
      n_fail++;
      $display("FAIL collision_risr: got %h, required 00000004", d);
    end
    // Disabling the enable must not clear the sticky status.
    bus_wr(OFF_RIER, 32'd0);
    bus_rd(OFF_RISR, d, d5, v);
    n_tests++;
    if (d !== 32'h4 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_after_disable: risr=%h irq=%b, required 00000004 / 1", d, irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, d5;
    logic        v;
    bus_wr(OFF_FIER, 32'h5);
    bus_rd(OFF_FIER, d, d5, v);
    n_tests++;
    if (d !== 32'h5 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: data=%h rvalid=%b, required 00000005 / 1", d, v);
    end
    n_tests++;
    if (bus_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rvalid_pulse_width: rvalid=%b at read, required 1", bus_rvalid);
    end
    @(negedge clk);
    n_tests++;
    if (bus_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_idle: rvalid=%b, required 0", bus_rvalid);
    end
  endtask

  task automatic test_width5();
    logic [31:0] d, d5;
    logic        v;
    bus_wr(OFF_ODR,  32'hFFFF_FFFF);
    bus_wr(OFF_RIER, 32'hFFFF_FFFF);
    bus_wr(OFF_DIR,  32'hFFFF_FFFF);
    bus_rd(OFF_ODR, d, d5, v);
    n_tests++;
    if (d5 !== 32'h1F || d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL width5_odr: w5=%h w32=%h, required 0000001f / ffffffff", d5, d);
    end
    bus_rd(OFF_RIER, d, d5, v);
    n_tests++;
    if (d5 !== 32'h1F) begin
      n_fail++;
      $display("FAIL width5_rier: got %h, required 0000001f", d5);
    end
    bus_rd(OFF_DIR, d, d5, v);
    n_tests++;
    if (d5 !== 32'h1F || gpio_oe5 !== 5'h1F || gpio_out5 !== 5'h1F) begin
      n_fail++;
      $display("FAIL width5_dir: dir=%h oe=%h out=%h, required 0000001f / 1f / 1f",
               d5, gpio_oe5, gpio_out5);
    end
    bus_wr(12'h028, 32'hFFFF_FFFF);
    bus_rd(12'h028, d, d5, v);
    n_tests++;
    if (d !== 32'd0 || d5 !== 32'd0) begin
      n_fail++;
      $display("FAIL undefined_offset: w32=%h w5=%h, required 0", d, d5);
    end
  endtask

  initial begin
    rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    gpio_in = '0; gpio_in5 = '0;
    @(negedge clk);
    test_reset();
    test_atomic_odr();
    test_edge_irq();
    test_debounce();
    test_collision();
    test_back_to_back();
    test_width5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
